// File: rtl/keypad_scanner_if.sv
// rtl/keypad_scanner_if.sv - keypad matrix and key-event signal bundle
interface keypad_scanner_if;
    logic [3:0] row_n;
    logic [2:0] col_n;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;

    modport master (
        input  row_n,
        output col_n,
        output key,
        output key_valid,
        output key_down
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key,
        input  key_valid,
        input  key_down
    );
endinterface

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x3 keypad column scanner with frame debounce and one-shot key strobe
module keypad_scanner #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    keypad_scanner_if.master  kp
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [3:0]       NO_KEY   = 4'd15;

    typedef enum logic [1:0] {S_IDLE, S_DEBOUNCE, S_EMIT, S_HELD} state_t;

    logic             started;
    logic [DIV_W-1:0] div;
    logic [1:0]       col;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_code;
    logic [2:0]       col_n_q;
    state_t           state;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       key_q;
    logic             key_valid_q;
    logic             key_down_q;

    logic             sample;
    logic             frame_done;
    logic [2:0]       col_cnt;
    logic [3:0]       col_code;
    logic [2:0]       sum_hits;
    logic [3:0]       frame_code;
    logic             is_empty;
    logic             is_single;
    logic [1:0]       next_col;
    logic [CNT_W-1:0] cnt_inc;

    function automatic logic [3:0] encode(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        if (r == 2'd3) begin
            case (c)
                2'd0:    code = 4'd10;
                2'd1:    code = 4'd0;
                default: code = 4'd11;
            endcase
        end else begin
            code = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
        end
        return code;
    endfunction

    assign sample     = started && (div == DIV_LAST);
    assign frame_done = sample && (col == 2'd2);
    assign next_col   = (col == 2'd2) ? 2'd0 : col + 2'd1;
    assign cnt_inc    = cnt + 1'b1;

    always_comb begin
        col_cnt  = 3'd0;
        col_code = NO_KEY;
        for (int r = 3; r >= 0; r--) begin
            if (!kp.row_n[r]) begin
                col_cnt  = col_cnt + 3'd1;
                col_code = encode(2'(r), col);
            end
        end
    end

    // Hits are carried saturated at 2: anything past one is already MULTI.
    assign sum_hits   = {1'b0, acc_hits} + col_cnt;
    assign frame_code = (acc_hits == 2'd1) ? acc_code : col_code;
    assign is_empty   = (sum_hits == 3'd0);
    assign is_single  = (sum_hits == 3'd1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            started  <= 1'b0;
            div      <= '0;
            col      <= 2'd0;
            col_n_q  <= 3'b111;
            acc_hits <= 2'd0;
            acc_code <= NO_KEY;
        end else if (!started) begin
            started <= 1'b1;
            col_n_q <= 3'b110;
        end else if (sample) begin
            div     <= '0;
            col     <= next_col;
            col_n_q <= ~(3'b001 << next_col);
            if (frame_done) begin
                acc_hits <= 2'd0;
                acc_code <= NO_KEY;
            end else begin
                acc_hits <= (sum_hits >= 3'd2) ? 2'd2 : sum_hits[1:0];
                if (is_single)
                    acc_code <= frame_code;
            end
        end else begin
            div <= div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cand        <= NO_KEY;
            cnt         <= '0;
            key_q       <= NO_KEY;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (frame_done && is_single) begin
                        cand <= frame_code;
                        cnt  <= CNT_W'(1);
                        if (DEBOUNCE_SCANS == 1) begin
                            state       <= S_EMIT;
                            key_q       <= frame_code;
                            key_valid_q <= 1'b1;
                            key_down_q  <= 1'b1;
                        end else begin
                            state <= S_DEBOUNCE;
                        end
                    end
                end
                S_DEBOUNCE: begin
                    if (frame_done) begin
                        if (is_single && frame_code == cand) begin
                            cnt <= cnt_inc;
                            if (cnt_inc == CNT_LAST) begin
                                state       <= S_EMIT;
                                key_q       <= cand;
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                            end
                        end else begin
                            state <= S_IDLE;
                            cnt   <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    state       <= S_HELD;
                    cnt         <= '0;
                    key_q       <= NO_KEY;
                    key_valid_q <= 1'b0;
                end
                S_HELD: begin
                    // Any non-empty frame, even another key, restarts the release count.
                    if (frame_done) begin
                        if (is_empty) begin
                            if (cnt_inc == CNT_LAST) begin
                                state      <= S_IDLE;
                                cnt        <= '0;
                                key_down_q <= 1'b0;
                            end else begin
                                cnt <= cnt_inc;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign kp.col_n     = col_n_q;
    assign kp.key       = key_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - scoreboard bench for keypad_scanner
module tb_keypad_scanner;
    localparam int SCAN_DIV       = 4;
    localparam int DEBOUNCE_SCANS = 3;
    localparam int PULSE_CYC      = 3 * SCAN_DIV * DEBOUNCE_SCANS + 1;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0][2:0] press = '0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    bit   kd_seen = 1'b0;
    exp_t exp_q[$];

    keypad_scanner_if kp();

    keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEBOUNCE_SCANS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int r = 0; r < 4; r++)
            kp.row_n[r] = ~(|(press[r] & ~kp.col_n));
    end

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (mon_en) begin
            exp_t e;
            if (kp.key_down === 1'b1) kd_seen = 1'b1;
            checks++;
            if (kp.key_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got key=%0d at cyc=%0d, required no pulse", kp.key, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (kp.key !== e.code || cyc != e.cyc || kp.key_down !== 1'b1) begin
                        errors++;
                        $display("FAIL pulse: got key=%0d cyc=%0d key_down=%b, required key=%0d cyc=%0d key_down=1",
                                 kp.key, cyc, kp.key_down, e.code, e.cyc);
                    end
                end
            end else if (kp.key !== 4'd15 || kp.key_valid !== 1'b0) begin
                errors++;
                $display("FAIL idle_key: got key=%0d key_valid=%b at cyc=%0d, required key=15 key_valid=0",
                         kp.key, kp.key_valid, cyc);
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1 kd_seen = 1'b0;
    endtask

    task automatic test_reset;
        press = '0;
        rst_n = 1'b0;
        wait_cyc(2);
        checks++;
        if (kp.col_n !== 3'b111 || kp.key !== 4'd15 || kp.key_valid !== 1'b0 || kp.key_down !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got col_n=%b key=%0d kv=%b kd=%b, required 111 15 0 0",
                     kp.col_n, kp.key, kp.key_valid, kp.key_down);
        end
        mon_en = 1'b1;
        rst_n = 1'b1;
        wait_cyc(1);
        checks++;
        if (kp.col_n !== 3'b110) begin
            errors++;
            $display("FAIL first_column: got col_n=%b, required 110", kp.col_n);
        end
    endtask

    task automatic test_hold_one;
        press = '0;
        press[0][0] = 1'b1;
        exp_q.push_back('{4'd1, PULSE_CYC});
        apply_reset(2);
        wait_cyc(199);
        checks++;
        if (exp_q.size() != 0 || kp.key_down !== 1'b1) begin
            errors++;
            $display("FAIL hold_one_pulse: pending=%0d key_down=%b, required pending=0 key_down=1", exp_q.size(), kp.key_down);
            exp_q.delete();
        end
        press = '0;
        wait_cyc(40);
        checks++;
        if (kp.key_down !== 1'b1) begin
            errors++;
            $display("FAIL release_hold: got key_down=%b at cyc=%0d, required 1", kp.key_down, cyc);
        end
        wait_cyc(1);
        checks++;
        if (kp.key_down !== 1'b0) begin
            errors++;
            $display("FAIL release_drop: got key_down=%b at cyc=%0d, required 0", kp.key_down, cyc);
        end
    endtask

    task automatic test_bounce;
        press = '0;
        press[3][2] = 1'b1;
        apply_reset(2);
        wait_cyc(12);
        press = '0;
        wait_cyc(72);
        checks++;
        if (kd_seen !== 1'b0) begin
            errors++;
            $display("FAIL bounce_key_down: got key_down seen=%b, required 0", kd_seen);
        end
    endtask

    task automatic test_multi;
        press = '0;
        press[1][1] = 1'b1;
        press[2][2] = 1'b1;
        apply_reset(2);
        wait_cyc(120);
        press = '0;
        wait_cyc(24);
        checks++;
        if (kd_seen !== 1'b0) begin
            errors++;
            $display("FAIL multi_key_down: got key_down seen=%b, required 0", kd_seen);
        end
    endtask

    task automatic test_glitch;
        press = '0;
        press[0][1] = 1'b1;
        exp_q.push_back('{4'd2, PULSE_CYC});
        apply_reset(2);
        wait_cyc(72);
        press = '0;
        wait_cyc(12);
        checks++;
        if (kp.key_down !== 1'b1) begin
            errors++;
            $display("FAIL glitch_hold: got key_down=%b after 1 empty frame, required 1", kp.key_down);
        end
        press[0][1] = 1'b1;
        wait_cyc(48);
        press = '0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL glitch_pulse: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        wait_cyc(35);
        checks++;
        if (kp.key_down !== 1'b1) begin
            errors++;
            $display("FAIL glitch_release_hold: got key_down=%b at cyc=%0d, required 1", kp.key_down, cyc);
        end
        wait_cyc(1);
        checks++;
        if (kp.key_down !== 1'b0) begin
            errors++;
            $display("FAIL glitch_release_drop: got key_down=%b at cyc=%0d, required 0", kp.key_down, cyc);
        end
        wait_cyc(24);
    endtask

    task automatic test_reset_held;
        press = '0;
        press[3][1] = 1'b1;
        exp_q.push_back('{4'd0, PULSE_CYC});
        apply_reset(2);
        wait_cyc(50);
        checks++;
        if (exp_q.size() != 0 || kp.key_down !== 1'b1) begin
            errors++;
            $display("FAIL zero_first_pulse: pending=%0d key_down=%b, required 0 and 1", exp_q.size(), kp.key_down);
            exp_q.delete();
        end
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wait_cyc(1);
            checks++;
            if (kp.col_n !== 3'b111 || kp.key !== 4'd15 || kp.key_valid !== 1'b0 || kp.key_down !== 1'b0) begin
                errors++;
                $display("FAIL mid_reset: got col_n=%b key=%0d kv=%b kd=%b, required 111 15 0 0",
                         kp.col_n, kp.key, kp.key_valid, kp.key_down);
            end
        end
        exp_q.push_back('{4'd0, PULSE_CYC});
        rst_n = 1'b1;
        wait_cyc(1);
        kd_seen = 1'b0;
        wait_cyc(50);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL zero_second_pulse: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        press = '0;
        wait_cyc(60);
    endtask

    task automatic test_scan_star;
        logic [2:0] e;
        press = '0;
        press[3][0] = 1'b1;
        exp_q.push_back('{4'd10, PULSE_CYC});
        rst_n = 1'b0;
        wait_cyc(2);
        checks++;
        if (kp.col_n !== 3'b111) begin
            errors++;
            $display("FAIL scan_reset_col: got col_n=%b, required 111", kp.col_n);
        end
        rst_n = 1'b1;
        wait_cyc(1);
        for (int k = 0; k < 36; k++) begin
            case ((k / 4) % 3)
                0:       e = 3'b110;
                1:       e = 3'b101;
                default: e = 3'b011;
            endcase
            checks++;
            if (kp.col_n !== e) begin
                errors++;
                $display("FAIL col_seq: got col_n=%b at step %0d, required %b", kp.col_n, k, e);
            end
            wait_cyc(1);
        end
        wait_cyc(14);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL star_pulse: pending=%0d, required 0", exp_q.size());
            exp_q.delete();
        end
        press = '0;
        wait_cyc(60);
    endtask

    initial begin
        test_reset();
        test_hold_one();
        test_bounce();
        test_multi();
        test_glitch();
        test_reset_held();
        test_scan_star();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expect: pending=%0d, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4-row x 3-column telephone keypad matrix and debounces presses.
- Presents each accepted press on `key` as a single-cycle code pulse, for direct consumption by the voicemail control state machine.
- Holds `key` at the no-key code at all other times, so a held key cannot advance the downstream FSM repeatedly.

Parameters:
- SCAN_DIV, 4: clocks each column is driven before its rows are sampled (>=2).
- DEBOUNCE_SCANS, 3: consecutive identical full-scan frames required to accept a press or a release (>=1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active-low
- row_n  input  4  keypad rows, active-low, already synchronised; bit r = row r
- col_n  output  3  column drive, active-low one-hot; bit c = column c
- key  output  4  key code; valid only in the key_valid cycle, 4'd15 otherwise
- key_valid  output  1  one-cycle strobe with the accepted key code
- key_down  output  1  high while an accepted key is still held

Behaviour:
- Reset:
  - Synchronous, active-low; single clock domain clk.
  - While rst_n=0: col_n=3'b111, key=4'd15, key_valid=0, key_down=0; scan counters and FSM cleared.
  - Scanning starts the first cycle after release, at column 0.
- Key encoding (row r, col c):
  - Rows 0-2: code = 3r+c+1 (digits 1-9).
  - Row 3: col0 star=4'd10, col1 zero=4'd0, col2 pound=4'd11.
  - No key = 4'd15.
- Scan:
  - Divider counts 0..SCAN_DIV-1. While column c is active, col_n bit c = 0 and all other bits = 1.
  - row_n is sampled on divider = SCAN_DIV-1, then the column index advances 0->1->2->0.
  - One frame = 3*SCAN_DIV clocks. A frame_done strobe fires on the column-2 sample cycle.
- Frame result:
  - Counts asserted (low) rows across the 3 column samples.
  - 0 hits = EMPTY; exactly 1 = SINGLE(code); >1 = MULTI.
  - MULTI is treated as neither a new key nor a release.
- FSM (updates only on frame_done, except EMIT):
  - IDLE:
    - SINGLE(k): cand<=k, cnt<=1; go to EMIT if DEBOUNCE_SCANS=1, else DEBOUNCE.
    - Otherwise stay.
  - DEBOUNCE:
    - SINGLE(cand): cnt++; at cnt=DEBOUNCE_SCANS go to EMIT.
    - Any other result: go to IDLE.
  - EMIT:
    - Lasts exactly one clock: key=cand, key_valid=1, key_down=1.
    - Next state HELD, cnt<=0.
  - HELD:
    - key_down=1.
    - EMPTY: cnt++; at cnt=DEBOUNCE_SCANS go to IDLE.
    - SINGLE/MULTI: cnt<=0; a different key pressed while held is ignored.
- Outputs:
  - key_valid is high only in EMIT; key=4'd15 in every other cycle.
  - key_down is low in IDLE and DEBOUNCE.
  - All outputs are registered.
- Latency: a press stable from the start of a frame produces key_valid exactly one clock after the DEBOUNCE_SCANS-th matching frame_done.
- Boundaries:
  - A bounce shorter than DEBOUNCE_SCANS frames produces no strobe.
  - Release glitches shorter than DEBOUNCE_SCANS empty frames do not re-arm the FSM.
  - Reset mid-HELD returns to IDLE; a key still held after reset is re-accepted through the full debounce.
  - Counters wrap only at their defined limits; cnt saturates and never exceeds DEBOUNCE_SCANS.

Test Plan:
1. Defaults, hold key '1' (row0, col0) for 200 clocks:
   - Exactly one key_valid pulse, with key=4'd1.
   - Pulse occurs one clock after the 3rd matching frame_done.
   - key_down stays high until 3 empty frames after release.
   - key=4'd15 on every other cycle.
2. Press pound (row3, col2) for 1 frame only, then release: no key_valid, key_down stays 0.
3. Press '5' (row1, col1) and '9' (row2, col2) together for 10 frames: MULTI on every frame, no key_valid.
4. Hold '2' for 6 frames, glitch-release for 1 frame, continue holding for 4 frames, then release:
   - Single pulse with key=4'd2.
   - No second pulse.
5. Hold '0'; after its pulse, assert rst_n=0 for 2 clocks while still holding:
   - During reset: outputs at reset values, col_n=3'b111.
   - After reset: a second pulse with key=4'd0, after 3 frames.
6. Check col_n sequence after reset: 110 for 4 clocks, then 101 for 4, then 011 for 4, repeating.
   - Star (row3, col0) held produces key=4'd10.
